// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
//   Pipeline register between instruction fetch and operand/execute. Words
//   arrive on a valid/ready handshake and are decoded into register fields
//   plus the control bits for the immediate extender. A two-entry skid buffer
//   (OUT + SKID) lets in_ready come straight from a flop. flush squashes every
//   held word.
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   in_valid/in_ready   fetch handshake (in_ready is registered)
//   in_instr, in_pc     instruction word and its PC tag
//   flush               synchronous squash of all held words
//   out_valid/out_ready downstream handshake
//   out_pc              PC tag of the word on the outputs
//   opcode..shamt       register fields sliced from the held word
//   imm16, ext_ops      immediate and extender control (00 zero, 01 sign, 10 lui)
//   illegal             opcode not in the supported table
// -----------------------------------------------------------------------------
module decode_stage #(
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [5:0]      opcode,
  output logic [5:0]      funct,
  output logic [4:0]      rs,
  output logic [4:0]      rt,
  output logic [4:0]      rd,
  output logic [4:0]      shamt,
  output logic [15:0]     imm16,
  output logic [1:0]      ext_ops,
  output logic            illegal
);

  typedef enum logic [1:0] {
    EXT_ZERO = 2'b00,
    EXT_SIGN = 2'b01,
    EXT_HI16 = 2'b10
  } ext_op_e;

  typedef struct packed {
    ext_op_e ext;
    logic    illegal;
  } dec_t;

  // Opcode table. Unknown opcodes still pass through, flagged illegal and
  // zero-extended so ext_ops never reaches 11.
  function automatic dec_t decode(input logic [5:0] op);
    dec_t d;
    d.ext     = EXT_ZERO;
    d.illegal = 1'b0;
    unique case (op)
      6'h23, 6'h2B, 6'h08, 6'h09,
      6'h0A, 6'h0B, 6'h04, 6'h05: d.ext = EXT_SIGN;
      6'h0F:                      d.ext = EXT_HI16;
      6'h00, 6'h0C, 6'h0D,
      6'h0E, 6'h02, 6'h03:        d.ext = EXT_ZERO;
      default:                    d.illegal = 1'b1;
    endcase
    return d;
  endfunction

  logic            out_valid_q, out_valid_d;
  logic [31:0]     out_instr_q, out_instr_d;
  logic [PC_W-1:0] out_pc_q,    out_pc_d;
  dec_t            dec_q,       dec_d;
  logic            skid_valid_q, skid_valid_d;
  logic [31:0]     skid_instr_q, skid_instr_d;
  logic [PC_W-1:0] skid_pc_q,    skid_pc_d;
  logic            in_ready_q,   in_ready_d;

  logic accept;
  logic consume;

  assign accept  = in_valid & in_ready_q;
  assign consume = out_valid_q & out_ready;

  always_comb begin
    // NOTE: every _d starts as its _q so no path leaves a signal unassigned,
    // which would otherwise infer a latch.
    out_valid_d  = out_valid_q;
    out_instr_d  = out_instr_q;
    out_pc_d     = out_pc_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;

    if (flush) begin
      // Held words and the word offered this cycle are all dropped; a consume
      // in the same cycle has already been seen by downstream.
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || consume) begin
      if (skid_valid_q) begin
        // in_ready was low, so no new word can arrive alongside the skid move.
        out_valid_d  = 1'b1;
        out_instr_d  = skid_instr_q;
        out_pc_d     = skid_pc_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_valid_d = 1'b1;
        out_instr_d = in_instr;
        out_pc_d    = in_pc;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      // OUT is stalled; in_ready implies SKID is free.
      skid_valid_d = 1'b1;
      skid_instr_d = in_instr;
      skid_pc_d    = in_pc;
    end

    // Decoding the next OUT word keeps ext_ops/illegal in step with it; when
    // OUT holds, this recomputes the same value.
    dec_d      = decode(out_instr_d[31:26]);
    in_ready_d = ~skid_valid_d;
  end

  // NOTE: state updates use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q  <= 1'b0;
      out_instr_q  <= '0;
      out_pc_q     <= '0;
      dec_q        <= '0;
      skid_valid_q <= 1'b0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      in_ready_q   <= 1'b1;
    end else begin
      out_valid_q  <= out_valid_d;
      out_instr_q  <= out_instr_d;
      out_pc_q     <= out_pc_d;
      dec_q        <= dec_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_pc    = out_pc_q;
  assign opcode    = out_instr_q[31:26];
  assign rs        = out_instr_q[25:21];
  assign rt        = out_instr_q[20:16];
  assign rd        = out_instr_q[15:11];
  assign shamt     = out_instr_q[10:6];
  assign funct     = out_instr_q[5:0];
  assign imm16     = out_instr_q[15:0];
  assign ext_ops   = dec_q.ext;
  assign illegal   = dec_q.illegal;

endmodule
